// File: rtl/key_enc_pkg.sv
// Shared types, defaults and encode helpers for the key encoder.
package key_enc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    localparam int DEF_NUM_KEYS   = 10;
    localparam int DEF_CODE_W     = 4;
    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic logic [5:0] prio_enc(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    function automatic logic [6:0] pop_cnt(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/key_code_fifo.sv
// Small code buffer; head is presented combinationally and gated by valid.
module key_code_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign valid   = (count != '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & valid;
    // A pop frees a slot in the same cycle, so a full buffer still accepts
    assign do_push = push & (~full | do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            ovf <= push & ~do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/key_encoder_fifo.sv
// Keypad front end: synchronise, debounce, encode press events, buffer codes.
module key_encoder_fifo
    import key_enc_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int CODE_W     = DEF_CODE_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] p0,
    output logic [CODE_W-1:0]   p1,
    output logic                MULTI,
    output logic                VALID,
    input  logic                READY,
    output logic                CHK,
    output logic                OVF
);

    if (NUM_KEYS < 2 || NUM_KEYS > 64) begin : g_bad_keys
        $error("NUM_KEYS must be 2..64");
    end
    if ((2 ** CODE_W) < NUM_KEYS) begin : g_bad_code
        $error("CODE_W too narrow for NUM_KEYS");
    end
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("DEB_CYCLES must be 1..255");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);
    localparam logic [7:0] DEB_M1  = 8'(DEB_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] last;
    logic [NUM_KEYS-1:0] deb;
    logic [NUM_KEYS-1:0] deb_d;
    logic [7:0]          stable_cnt;
    logic [63:0]         deb_ext;
    key_state_t          state;
    key_state_t          state_d;
    logic                press;
    logic                evt;
    logic [CODE_W-1:0]   evt_code;
    logic                evt_multi;
    logic                chk_q;
    logic                pop;

    // stable_cnt counts edges the synchronised vector has held its value
    always_comb begin
        deb_d = deb;
        if (sync2 == last && stable_cnt >= DEB_M1) deb_d = sync2;
    end

    assign deb_ext = 64'(deb_d);

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (|deb_d)  state_d = ST_HELD;
            ST_HELD: if (~|deb_d) state_d = ST_IDLE;
        endcase
    end

    assign press = (state == ST_IDLE) && (state_d == ST_HELD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1      <= '0;
            sync2      <= '0;
            last       <= '0;
            stable_cnt <= '0;
            deb        <= '0;
            state      <= ST_IDLE;
            evt        <= 1'b0;
            evt_code   <= '0;
            evt_multi  <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            sync1 <= p0;
            sync2 <= sync1;
            last  <= sync2;
            if (sync2 != last)          stable_cnt <= '0;
            else if (stable_cnt != DEB_MAX) stable_cnt <= stable_cnt + 1'b1;
            deb       <= deb_d;
            state     <= state_d;
            evt       <= press;
            evt_code  <= CODE_W'(prio_enc(deb_ext));
            evt_multi <= (pop_cnt(deb_ext) > 7'd1);
            chk_q     <= |deb_d;
        end
    end

    assign pop = VALID & READY;
    assign CHK = chk_q;

    key_code_fifo #(
        .W    (CODE_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RST),
        .push (evt),
        .din  ({evt_code, evt_multi}),
        .pop  (pop),
        .dout ({p1, MULTI}),
        .valid(VALID),
        .ovf  (OVF)
    );

endmodule

// File: tb/tb_key_encoder_fifo.sv
// Directed bench for key_encoder_fifo at NUM_KEYS=10, DEB=4, DEPTH=4.
module tb_key_encoder_fifo;

    logic       CLK;
    logic       RST;
    logic [9:0] p0;
    logic [3:0] p1;
    logic       MULTI;
    logic       VALID;
    logic       READY;
    logic       CHK;
    logic       OVF;

    int errors = 0;
    int checks = 0;

    key_encoder_fifo #(
        .NUM_KEYS  (10),
        .CODE_W    (4),
        .DEB_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .p0   (p0),
        .p1   (p1),
        .MULTI(MULTI),
        .VALID(VALID),
        .READY(READY),
        .CHK  (CHK),
        .OVF  (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] keys;
        logic [3:0] code;
        logic       multi;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive keys and record the first edge at which VALID is seen
    task automatic measure(input logic [9:0] keys, output int lat,
                           output logic [3:0] code, output logic mul,
                           output logic chk);
        lat  = 0;
        code = '0;
        mul  = 1'b0;
        chk  = 1'b0;
        p0   = keys;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (VALID && lat == 0) begin
                lat  = e;
                code = p1;
                mul  = MULTI;
                chk  = CHK;
            end
        end
    endtask

    task automatic press_release(input logic [9:0] keys, output int ovf_n);
        ovf_n = 0;
        p0 = keys;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OVF) ovf_n++;
        end
        p0 = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OVF) ovf_n++;
        end
    endtask

    task automatic pop_one();
        READY = 1'b1;
        tick();
        READY = 1'b0;
    endtask

    initial begin
        int         lat;
        int         ovf_n;
        int         bad;
        logic [3:0] code;
        logic       mul;
        logic       chk;

        vecs[0] = '{10'h008, 4'd3, 1'b0};
        vecs[1] = '{10'h204, 4'd9, 1'b1};
        vecs[2] = '{10'h001, 4'd0, 1'b0};
        vecs[3] = '{10'h3FF, 4'd9, 1'b1};
        vecs[4] = '{10'h200, 4'd9, 1'b0};
        vecs[5] = '{10'h006, 4'd2, 1'b1};

        RST   = 1'b0;
        READY = 1'b0;
        p0    = '0;
        #2 RST = 1'b1;
        #1;
        check("rst_outputs", {p1, MULTI, VALID, CHK, OVF}, '0);
        tick();
        tick();
        RST = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (VALID || CHK || OVF) bad++;
        end
        check("idle_quiet_20", bad, 0);

        READY = 1'b1;
        measure(10'h008, lat, code, mul, chk);
        check("ready1_latency", lat, 8);
        check("ready1_code", code, 4'd3);
        check("ready1_chk", chk, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (VALID) bad++;
        end
        check("ready1_single_event", bad, 0);
        p0 = '0;
        READY = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("ready1_release_chk", CHK, 1'b0);

        for (int v = 0; v < 6; v++) begin
            measure(vecs[v].keys, lat, code, mul, chk);
            check($sformatf("vec%0d_latency", v), lat, 8);
            check($sformatf("vec%0d_code", v), code, vecs[v].code);
            check($sformatf("vec%0d_multi", v), mul, vecs[v].multi);
            check($sformatf("vec%0d_chk", v), chk, 1'b1);
            pop_one();
            p0 = '0;
            for (int i = 0; i < 12; i++) tick();
            check($sformatf("vec%0d_single", v), VALID, 1'b0);
            check($sformatf("vec%0d_chk_off", v), CHK, 1'b0);
        end

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            p0 = ((i / 2) % 2 == 0) ? 10'h001 : 10'h000;
            tick();
            if (VALID || CHK) bad++;
        end
        p0 = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (VALID || CHK) bad++;
        end
        check("bounce_no_event", bad, 0);

        measure(10'h204, lat, code, mul, chk);
        check("held_code", code, 4'd9);
        check("held_multi", mul, 1'b1);
        pop_one();
        p0 = 10'h224;
        for (int i = 0; i < 15; i++) tick();
        check("held_add_no_event", VALID, 1'b0);
        check("held_chk", CHK, 1'b1);
        p0 = '0;
        for (int i = 0; i < 12; i++) tick();

        for (int k = 1; k <= 4; k++) begin
            press_release(10'(1 << k), ovf_n);
            check($sformatf("fill%0d_no_ovf", k), ovf_n, 0);
        end
        press_release(10'h020, ovf_n);
        check("fill5_ovf_pulse", ovf_n, 1);
        check("hold_head", p1, 4'd1);
        tick();
        tick();
        check("hold_stable", {VALID, p1, MULTI}, {1'b1, 4'd1, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d", k), {VALID, p1, MULTI},
                  {1'b1, 4'(k), 1'b0});
            pop_one();
        end
        check("drain_empty", VALID, 1'b0);
        pop_one();
        check("ready_when_empty", {VALID, OVF}, 2'b00);

        for (int k = 1; k <= 4; k++) press_release(10'(1 << k), ovf_n);
        ovf_n = 0;
        p0 = 10'h040;
        for (int i = 0; i < 7; i++) tick();
        READY = 1'b1;
        tick();
        READY = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (OVF) ovf_n++;
        end
        p0 = '0;
        check("full_pushpop_no_ovf", ovf_n, 0);
        check("full_pushpop_head", p1, 4'd2);
        pop_one();
        pop_one();
        check("after_rem_4", p1, 4'd4);
        pop_one();
        check("new_code_last", {VALID, p1}, {1'b1, 4'd6});
        #2 RST = 1'b1;
        #1;
        check("rst_mid_drain", {VALID, p1, MULTI, CHK, OVF}, '0);

        p0 = 10'h010;
        tick();
        tick();
        tick();
        RST = 1'b0;
        measure(10'h010, lat, code, mul, chk);
        check("rst_held_latency", lat, 8);
        check("rst_held_code", code, 4'd4);
        pop_one();
        for (int i = 0; i < 10; i++) tick();
        check("rst_held_single", VALID, 1'b0);
        p0 = '0;
        for (int i = 0; i < 12; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_encoder_fifo.md
KEY_ENCODER_FIFO -- requirements
Module: key_encoder_fifo

Interface
REQ-001 Parameter NUM_KEYS, default 10: number of raw key inputs, range 2..64.
REQ-002 Parameter CODE_W, default 4: encoded key width; SHALL satisfy 2**CODE_W >= NUM_KEYS (elaboration error otherwise).
REQ-003 Parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a key-vector change, range 1..255.
REQ-004 Parameter FIFO_DEPTH, default 4: code buffer entries, power of two, range 2..16.
REQ-005 CLK  input  1  sole clock, all state on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 p0  input  NUM_KEYS  raw key lines, bit i = key i pressed, asynchronous to CLK.
REQ-008 p1  output  CODE_W  encoded code at FIFO head.
REQ-009 MULTI  output  1  head entry was captured with more than one key pressed.
REQ-010 VALID  output  1  FIFO non-empty; p1/MULTI meaningful.
REQ-011 READY  input  1  consumer accepts head when VALID & READY.
REQ-012 CHK  output  1  any debounced key currently pressed.
REQ-013 OVF  output  1  one-cycle pulse: press event dropped, FIFO full.

Function
REQ-014 Each p0 bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-015 Debounce: counter clears on any change of the synchronised vector; debounced vector loads the synchronised vector on the edge where it has been unchanged for DEB_CYCLES consecutive edges; counter saturates, no wrap.
REQ-016 FSM states IDLE (debounced vector zero) and HELD (non-zero); IDLE->HELD on debounced vector becoming non-zero, HELD->IDLE on it becoming zero.
REQ-017 A press event SHALL occur only on the IDLE->HELD transition; key changes while in HELD produce no event.
REQ-018 Event code = index of highest-numbered set bit of the debounced vector (priority encode), zero-extended to CODE_W; MULTI bit = popcount > 1.
REQ-019 Event {code, multi} SHALL be written to the FIFO on the edge after the transition; VALID rises the following cycle; total latency raw edge -> VALID = DEB_CYCLES + 4 edges.
REQ-020 FIFO pops on VALID & READY; p1/MULTI update to next entry the same edge; p1/MULTI SHALL hold stable while VALID & !READY.
REQ-021 READY while VALID low SHALL have no effect.
REQ-022 Push and pop in the same cycle when full: both performed, no OVF.
REQ-023 Push when full without pop: entry dropped, FIFO unchanged, OVF high exactly one cycle.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-025 CHK SHALL equal OR of debounced vector, registered, no dependency on FIFO.

Reset
REQ-026 RST high SHALL immediately clear synchronisers, debounce counter, debounced vector, FSM (IDLE), FIFO pointers/occupancy; outputs p1=0, MULTI=0, VALID=0, CHK=0, OVF=0.
REQ-027 RST mid-operation discards buffered codes; a key held through reset release SHALL generate one event after full debounce latency.

Structure
REQ-028 Package key_enc_pkg SHALL hold FSM state enum, default parameter constants and the priority-encode and popcount functions.
REQ-029 FIFO SHALL be a sub-module key_code_fifo (parametrised width CODE_W+1, depth FIFO_DEPTH); all other logic in key_encoder_fifo.

Verification (NUM_KEYS=10, DEB_CYCLES=4, FIFO_DEPTH=4)
REQ-030 Reset, p0 = 0 -> all outputs 0, VALID stays 0 for 20 cycles.
REQ-031 p0 = 10'h008 held, READY=1 -> VALID high exactly 8 edges later, p1=3, MULTI=0, CHK=1; single event only.
REQ-032 p0 toggles 10'h001/0 every 2 cycles for 20 cycles then 0 -> no event, CHK stays 0.
REQ-033 p0 = 10'h204 -> p1=9, MULTI=1; adding bit 5 while held -> no second event.
REQ-034 READY=0, five separate presses of keys 1..5 -> FIFO holds 1,2,3,4; fifth press OVF one-cycle pulse; draining yields 1,2,3,4 in order.
REQ-035 Full FIFO, READY=1 during a press push -> no OVF, new code appears after the remaining entries; RST asserted mid-drain -> VALID=0 immediately.
